multiplexer: RTL and testbench



---
 rtl/multiplexer.sv | 57 +++++
 tb/tb_multiplexer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multiplexer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiplexer: registered 4-to-1 word mux with enable and valid flag  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

module multiplexer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_d;
  logic             y_valid_q;

  // Disabled or unknown select steers zero into the register.
  always_comb begin
    y_d       = '0;
    y_valid_d = en;
    if (en) begin
      case (s)
        2'b00:   y_d = A;
        2'b01:   y_d = B;
        2'b10:   y_d = C;
        2'b11:   y_d = D;
        default: y_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign Y       = y_q;
  assign y_valid = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplexer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multiplexer: vector table plus scoreboard bench for multiplexer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

module tb_multiplexer;

  localparam int WIDTH = 4;

  typedef struct {
    logic             rst;
    logic             en;
    logic [1:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] y;
    logic             v;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             v;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [WIDTH-1:0] C = '0;
  logic [WIDTH-1:0] D = '0;
  logic             en = 1'b0;
  logic [1:0]       s = 2'b00;
  logic [WIDTH-1:0] Y;
  logic             y_valid;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  multiplexer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .en      (en),
    .s       (s),
    .Y       (Y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge and record what the next rising edge must produce.
  task automatic drive(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; s = v.s;
    A = v.a; B = v.b; C = v.c; D = v.d;
    e.y = v.y; e.v = v.v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: no expected entry for output Y=%h y_valid=%b", Y, y_valid);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (Y !== e.y || y_valid !== e.v) begin
        n_err++;
        $display("FAIL %s: got Y=%h y_valid=%b, expected Y=%h y_valid=%b",
                 e.name, Y, y_valid, e.y, e.v);
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] sel,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input logic [3:0] y, input logic v);
    vec_t t;
    t.rst = r; t.en = e; t.s = sel; t.a = a; t.b = b; t.c = c; t.d = d;
    t.y = y; t.v = v;
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] ref_mux(input vec_t t);
    if (t.rst || !t.en) return '0;
    case (t.s)
      2'b00:   return t.a;
      2'b01:   return t.b;
      2'b10:   return t.c;
      default: return t.d;
    endcase
  endfunction

  initial begin
    vec_t t;

    // Reset held two edges, then released with en=1, s=01.
    vecs.push_back(mk(1, 1, 2'b01, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 0));
    vecs.push_back(mk(1, 1, 2'b01, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 4'h1, 4'h2, 4'h3, 4'h1, 1));
    // Disabled sweep.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 2'(i), 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 0));
    // Enabled sweep.
    vecs.push_back(mk(0, 1, 2'b00, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1));
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 4'h1, 4'h2, 4'h3, 4'h1, 1));
    vecs.push_back(mk(0, 1, 2'b10, 4'h0, 4'h1, 4'h2, 4'h3, 4'h2, 1));
    vecs.push_back(mk(0, 1, 2'b11, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 1));
    // New data sweep.
    vecs.push_back(mk(0, 1, 2'b00, 4'h8, 4'hA, 4'hC, 4'hF, 4'h8, 1));
    vecs.push_back(mk(0, 1, 2'b01, 4'h8, 4'hA, 4'hC, 4'hF, 4'hA, 1));
    vecs.push_back(mk(0, 1, 2'b10, 4'h8, 4'hA, 4'hC, 4'hF, 4'hC, 1));
    vecs.push_back(mk(0, 1, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'hF, 1));
    // Enable toggle across three edges.
    vecs.push_back(mk(0, 1, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'hF, 1));
    vecs.push_back(mk(0, 0, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'h0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'hF, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], $sformatf("vec%0d", i));
      collect();
    end

    // Glitches on en and s between edges must not reach the output.
    drive(mk(0, 1, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'hF, 1), "en_glitch");
    #1 en = 1'b0;
    #1 en = 1'b1;
    collect();
    drive(mk(0, 1, 2'b11, 4'h8, 4'hA, 4'hC, 4'hF, 4'hF, 1), "s_glitch");
    #1 s = 2'b00;
    #1 s = 2'b11;
    collect();

    // Reset priority mid-stream with en held high.
    drive(mk(0, 1, 2'b10, 4'h8, 4'hA, 4'hC, 4'hF, 4'hC, 1), "rprio_pre");
    collect();
    drive(mk(1, 1, 2'b10, 4'h8, 4'hA, 4'hC, 4'hF, 4'h0, 0), "rprio_rst");
    collect();
    drive(mk(0, 1, 2'b10, 4'h8, 4'hA, 4'hC, 4'hF, 4'hC, 1), "rprio_post");
    collect();

    // Random traffic checked against a reference selection.
    for (int i = 0; i < 32; i++) begin
      t = mk($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'h0, 0);
      t.y = ref_mux(t);
      t.v = !t.rst && t.en;
      drive(t, $sformatf("rand%0d", i));
      collect();
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
